// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter onto a single registered-read RAM port.
// Reads carry a requester tag down a fixed-latency pipe so responses return in acceptance order.
module ram_port_arbiter #(
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic          a_req_we,
  input  logic [AW-1:0] a_req_addr,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_data,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic          b_req_we,
  input  logic [AW-1:0] b_req_addr,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_data,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned PD = RD_LAT + 1;

  logic          last_b;
  logic          a_grant_c;
  logic          b_grant_c;
  logic          acc_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic [PD-1:0] tag_vld;
  logic [PD-1:0] tag_b;

  // Grant: sole valid wins; on contention the one not granted last wins.
  always_comb begin
    a_grant_c   = 1'b0;
    b_grant_c   = 1'b0;
    sel_we_c    = 1'b0;
    sel_addr_c  = a_req_addr;
    sel_wdata_c = a_req_wdata;
    if (rst_n) begin
      a_grant_c = a_req_valid & (~b_req_valid | last_b);
      b_grant_c = b_req_valid & (~a_req_valid | ~last_b);
    end
    if (b_grant_c) begin
      sel_we_c    = b_req_we;
      sel_addr_c  = b_req_addr;
      sel_wdata_c = b_req_wdata;
    end else if (a_grant_c) begin
      sel_we_c = a_req_we;
    end
    acc_c = a_grant_c | b_grant_c;
  end

  assign a_req_ready = a_grant_c;
  assign b_req_ready = b_grant_c;

  // RAM command register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b    <= 1'b1;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= acc_c & sel_we_c;
      ram_re <= acc_c & ~sel_we_c;
      if (acc_c) begin
        last_b    <= b_grant_c;
        ram_addr  <= sel_addr_c;
        ram_wdata <= sel_wdata_c;
      end
    end
  end

  // Tag pipe: stage RD_LAT lines up with ram_rdata being valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      tag_b   <= '0;
    end else begin
      tag_vld[0] <= acc_c & ~sel_we_c;
      tag_b[0]   <= b_grant_c;
      for (int i = 1; i < int'(PD); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_b[i]   <= tag_b[i-1];
      end
    end
  end

  // Response capture; data holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= '0;
      b_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= tag_vld[RD_LAT] & ~tag_b[RD_LAT];
      b_rsp_valid <= tag_vld[RD_LAT] & tag_b[RD_LAT];
      if (tag_vld[RD_LAT] && !tag_b[RD_LAT]) a_rsp_data <= ram_rdata;
      if (tag_vld[RD_LAT] && tag_b[RD_LAT])  b_rsp_data <= ram_rdata;
    end
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 6, meaning RAM address width.
REQ-002 SHALL have parameter DW, default 8, meaning data width.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning cycles from ram_re sampled by the RAM to ram_rdata valid.
REQ-004 SHALL have ports as listed below; one clock; reset is asynchronous and active-low:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  a_req_valid  in  1  requester A command valid
  a_req_ready  out  1  requester A command accepted this cycle
  a_req_we  in  1  1 = write, 0 = read
  a_req_addr  in  AW  requester A address
  a_req_wdata  in  DW  requester A write data
  a_rsp_valid  out  1  requester A read data valid, one-cycle pulse
  a_rsp_data  out  DW  requester A read data
  b_req_valid / b_req_ready / b_req_we / b_req_addr / b_req_wdata / b_rsp_valid / b_rsp_data  same as A, for requester B
  ram_addr  out  AW  RAM port address
  ram_wdata  out  DW  RAM port write data
  ram_we  out  1  RAM write strobe
  ram_re  out  1  RAM read strobe
  ram_rdata  in  DW  RAM registered read data

Function
REQ-005 SHALL accept at most one command per cycle; a command is accepted when x_req_valid and x_req_ready are both 1.
REQ-006 SHALL derive a_req_ready/b_req_ready combinationally from valids and the round-robin pointer; ready SHALL never be 1 while the matching valid is 0.
REQ-007 SHALL grant the sole valid requester when only one is valid.
REQ-008 SHALL grant, when both are valid, the requester not granted most recently; the pointer SHALL update only on an accepted command.
REQ-009 SHALL drive ram_addr, ram_wdata, ram_we and ram_re from registers, one cycle after acceptance (accept in cycle N -> strobe in cycle N+1).
REQ-010 SHALL assert exactly one of ram_we or ram_re for exactly one cycle per accepted command; both SHALL be 0 in idle cycles.
REQ-011 SHALL hold ram_addr/ram_wdata at last values in idle cycles.
REQ-012 SHALL carry a requester tag through a shift pipeline of depth RD_LAT+1 for reads only.
REQ-013 SHALL register ram_rdata into x_rsp_data and pulse x_rsp_valid in cycle N+2+RD_LAT (cycle N+3 at default) for a read accepted in cycle N.
REQ-014 SHALL assert at most one of a_rsp_valid/b_rsp_valid per cycle, returning responses in acceptance order.
REQ-015 SHALL generate no response for writes.
REQ-016 SHALL provide no response back-pressure; requesters SHALL consume x_rsp_valid pulses when issued.
REQ-017 SHALL sustain back-to-back reads at one per cycle with responses on consecutive cycles.
REQ-018 SHALL return, for a read accepted in the cycle after a write to the same address, the newly written data (serialisation order guarantees it).
REQ-019 SHALL hold x_rsp_data at its last value when x_rsp_valid is 0.

Reset
REQ-020 SHALL on rst_n = 0, independent of clk, clear ram_we, ram_re, a_rsp_valid, b_rsp_valid, the tag pipeline, ram_addr, ram_wdata, a_rsp_data and b_rsp_data to 0.
REQ-021 SHALL initialise the round-robin pointer to "B last granted", so A wins the first contention.
REQ-022 SHALL drop all in-flight reads when reset is asserted mid-operation; no x_rsp_valid SHALL pulse for commands accepted before reset.
REQ-023 SHALL hold a_req_ready and b_req_ready at 0 while rst_n = 0.

Verification
REQ-024 SHALL cover: reset release, A writes 0x5A to addr 0x03 in cycle N -> ram_we=1, ram_addr=0x03, ram_wdata=0x5A in N+1; no rsp pulse.
REQ-025 SHALL cover: A reads addr 0x03 after REQ-024 write in cycle N -> a_rsp_valid=1, a_rsp_data=0x5A in N+3; b_rsp_valid stays 0.
REQ-026 SHALL cover: A and B both valid reads for 4 cycles after reset -> grants A,B,A,B; ram_re high 4 consecutive cycles; responses alternate A,B,A,B.
REQ-027 SHALL cover: B write 0xC3 to addr 0x3F, then A read addr 0x3F in the next cycle -> a_rsp_data=0xC3 (top-address boundary).
REQ-028 SHALL cover: reads accepted in cycles N and N+1, rst_n low in N+2 -> no rsp_valid pulses, all outputs 0 until first new acceptance; first contention after release grants A.
